// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad calculator sequencing controller.
package calc_pkg;

  localparam int DEF_W          = 12;
  localparam int DEF_MAX_DIGITS = 3;

  typedef enum logic [2:0] {
    S_A   = 3'd0,
    S_OP  = 3'd1,
    S_B   = 3'd2,
    S_RES = 3'd3,
    S_ERR = 3'd4
  } state_e;

  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;

  function automatic logic op_is_valid(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/calc_if.sv
// Key-event bundle from the keypad decoder and the display-path results back.
interface calc_if
  import calc_pkg::*;
#(
  parameter int W = DEF_W
);
  logic         key_valid;
  logic         is_number;
  logic         is_op;
  logic         is_eq;
  logic [3:0]   num_val;
  logic [1:0]   op_val;
  logic [W-1:0] disp_val;
  logic         err;
  logic         res_valid;
  logic [2:0]   state_o;

  modport master (
    output key_valid, is_number, is_op, is_eq, num_val, op_val,
    input  disp_val, err, res_valid, state_o
  );

  modport slave (
    input  key_valid, is_number, is_op, is_eq, num_val, op_val,
    output disp_val, err, res_valid, state_o
  );
endinterface

// File: rtl/calc_operand_acc.sv
// Next value of a decimal operand being typed: X*10+d with a digit-count limit
// and leading zeros not counted as significant digits.
module calc_operand_acc
  import calc_pkg::*;
#(
  parameter int W          = DEF_W,
  parameter int MAX_DIGITS = DEF_MAX_DIGITS,
  parameter int CW         = $clog2(MAX_DIGITS + 1)
) (
  input  logic [W-1:0]  x_i,
  input  logic [CW-1:0] cnt_i,
  input  logic [3:0]    d_i,
  output logic [W-1:0]  x_o,
  output logic [CW-1:0] cnt_o
);

  logic [W-1:0] x10_s;

  // Shift-add times ten, digit appended, gated by the digit limit
  always_comb begin
    x10_s = (x_i << 3) + (x_i << 1) + {{(W-4){1'b0}}, d_i};
    if (cnt_i < CW'(MAX_DIGITS)) begin
      x_o = x10_s;
      if ((x_i == {W{1'b0}}) && (d_i == 4'd0)) begin
        cnt_o = cnt_i;
      end else begin
        cnt_o = cnt_i + CW'(1);
      end
    end else begin
      x_o   = x_i;
      cnt_o = cnt_i;
    end
  end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencing FSM: operand entry, add/sub with overflow trap,
// operator chaining and a registered display value.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = DEF_MAX_DIGITS,
  parameter int W          = DEF_W
) (
  input  logic  clk,
  input  logic  reset_n,
  calc_if.slave kb
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, r_q, r_d, disp_q, disp_d;
  logic [1:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d, rv_q, rv_d;

  logic          ev_num_s, ev_op_s, ev_eq_s, nz_s, ovf_s;
  logic [W-1:0]  sel_x_s, acc_x_s, d_ext_s;
  logic [CW-1:0] acc_cnt_s;
  logic [W:0]    a_ext_s, b_ext_s, sum_s;

  // Only S_B accumulates into B; every other accumulate targets A
  assign sel_x_s = (state_q == S_B) ? b_q : a_q;
  assign d_ext_s = {{(W-4){1'b0}}, kb.num_val};
  assign nz_s    = (kb.num_val != 4'd0);

  calc_operand_acc #(.W(W), .MAX_DIGITS(MAX_DIGITS), .CW(CW)) u_acc (
    .x_i   (sel_x_s),
    .cnt_i (cnt_q),
    .d_i   (kb.num_val),
    .x_o   (acc_x_s),
    .cnt_o (acc_cnt_s)
  );

  // Event qualification with digit > op > eq priority
  always_comb begin
    ev_num_s = kb.key_valid && kb.is_number && (kb.num_val <= 4'd9);
    ev_op_s  = kb.key_valid && !kb.is_number && kb.is_op && op_is_valid(kb.op_val);
    ev_eq_s  = kb.key_valid && !kb.is_number && !kb.is_op && kb.is_eq;
  end

  // One guard bit: overflow when the two top bits of the sum disagree
  always_comb begin
    a_ext_s = {a_q[W-1], a_q};
    b_ext_s = {b_q[W-1], b_q};
    if (op_q == OP_SUB) begin
      sum_s = a_ext_s - b_ext_s;
    end else begin
      sum_s = a_ext_s + b_ext_s;
    end
    ovf_s = sum_s[W] ^ sum_s[W-1];
  end

  // Next-state, register updates and display source
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    rv_d    = 1'b0;
    case (state_q)
      S_A: begin
        if (ev_num_s) begin
          a_d   = acc_x_s;
          cnt_d = acc_cnt_s;
        end else if (ev_op_s) begin
          op_d    = kb.op_val;
          cnt_d   = {CW{1'b0}};
          state_d = S_OP;
        end else begin
          state_d = S_A;
        end
      end
      S_OP: begin
        if (ev_num_s) begin
          b_d     = d_ext_s;
          cnt_d   = CW'(nz_s);
          state_d = S_B;
        end else if (ev_op_s) begin
          op_d = kb.op_val;
        end else begin
          state_d = S_OP;
        end
      end
      S_B: begin
        if (ev_num_s) begin
          b_d   = acc_x_s;
          cnt_d = acc_cnt_s;
        end else if (ev_op_s || ev_eq_s) begin
          if (ovf_s) begin
            state_d = S_ERR;
          end else if (ev_op_s) begin
            r_d     = sum_s[W-1:0];
            a_d     = sum_s[W-1:0];
            op_d    = kb.op_val;
            cnt_d   = {CW{1'b0}};
            rv_d    = 1'b1;
            state_d = S_OP;
          end else begin
            r_d     = sum_s[W-1:0];
            rv_d    = 1'b1;
            state_d = S_RES;
          end
        end else begin
          state_d = S_B;
        end
      end
      S_RES: begin
        if (ev_num_s) begin
          a_d     = d_ext_s;
          cnt_d   = CW'(nz_s);
          state_d = S_A;
        end else if (ev_op_s) begin
          a_d     = r_q;
          op_d    = kb.op_val;
          cnt_d   = {CW{1'b0}};
          state_d = S_OP;
        end else begin
          state_d = S_RES;
        end
      end
      S_ERR: begin
        if (ev_num_s) begin
          a_d     = d_ext_s;
          b_d     = {W{1'b0}};
          r_d     = {W{1'b0}};
          cnt_d   = CW'(nz_s);
          state_d = S_A;
        end else begin
          state_d = S_ERR;
        end
      end
      default: begin
        state_d = S_A;
      end
    endcase

    case (state_d)
      S_A, S_OP: disp_d = a_d;
      S_B:       disp_d = b_d;
      S_RES:     disp_d = r_d;
      default:   disp_d = {W{1'b0}};
    endcase
    err_d = (state_d == S_ERR);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_A;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      r_q     <= {W{1'b0}};
      op_q    <= 2'd0;
      cnt_q   <= {CW{1'b0}};
      disp_q  <= {W{1'b0}};
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
    end
  end

  assign kb.disp_val  = disp_q;
  assign kb.err       = err_q;
  assign kb.res_valid = rv_q;
  assign kb.state_o   = state_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed plus randomized key sequences for calc_ctrl, checked against an
// integer-arithmetic model of the calculator.
module tb_calc_ctrl;
  import calc_pkg::*;

  localparam int W    = 12;
  localparam int MAXD = 3;
  localparam int VMAX = (1 << (W - 1)) - 1;
  localparam int VMIN = -(1 << (W - 1));

  logic clk = 1'b0;
  logic reset_n;

  calc_if #(.W(W)) kb ();

  calc_ctrl #(.MAX_DIGITS(MAXD), .W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .kb      (kb)
  );

  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_err = 0;
  state_e m_state;
  int     m_a, m_b, m_r, m_op, m_cnt;
  logic   m_rv;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_A;
    m_a = 0; m_b = 0; m_r = 0; m_op = 0; m_cnt = 0;
    m_rv = 1'b0;
  endtask

  function automatic int type_digit(input int x, inout int cnt, input int d);
    if (cnt >= MAXD) return x;
    if (!(x == 0 && d == 0)) cnt++;
    return x * 10 + d;
  endfunction

  task automatic model_event(input logic kv, input logic isn, input logic iso,
                             input logic ise, input logic [3:0] nv, input logic [1:0] ov);
    bit dig, opk, eqk;
    int d, res;
    d    = int'(nv);
    dig  = kv && isn && (d <= 9);
    opk  = kv && !isn && iso && (ov == 2'd1 || ov == 2'd2);
    eqk  = kv && !isn && !iso && ise;
    m_rv = 1'b0;
    case (m_state)
      S_A:
        if (dig) m_a = type_digit(m_a, m_cnt, d);
        else if (opk) begin m_op = int'(ov); m_cnt = 0; m_state = S_OP; end
      S_OP:
        if (dig) begin m_b = d; m_cnt = (d != 0); m_state = S_B; end
        else if (opk) m_op = int'(ov);
      S_B:
        if (dig) m_b = type_digit(m_b, m_cnt, d);
        else if (opk || eqk) begin
          res = (m_op == 2) ? m_a - m_b : m_a + m_b;
          if (res > VMAX || res < VMIN) m_state = S_ERR;
          else begin
            m_r  = res;
            m_rv = 1'b1;
            if (opk) begin m_a = res; m_op = int'(ov); m_cnt = 0; m_state = S_OP; end
            else m_state = S_RES;
          end
        end
      S_RES:
        if (dig) begin m_a = d; m_cnt = (d != 0); m_state = S_A; end
        else if (opk) begin m_a = m_r; m_op = int'(ov); m_state = S_OP; end
      default:
        if (dig) begin m_a = d; m_b = 0; m_r = 0; m_cnt = (d != 0); m_state = S_A; end
    endcase
  endtask

  task automatic check_all(input string tag);
    int           shown;
    logic [W-1:0] e_disp;
    case (m_state)
      S_A, S_OP: shown = m_a;
      S_B:       shown = m_b;
      S_RES:     shown = m_r;
      default:   shown = 0;
    endcase
    e_disp = shown[W-1:0];
    cmp({tag, ".disp"},  32'(kb.disp_val),  32'(e_disp));
    cmp({tag, ".err"},   32'(kb.err),       32'(m_state == S_ERR));
    cmp({tag, ".rv"},    32'(kb.res_valid), 32'(m_rv));
    cmp({tag, ".state"}, 32'(kb.state_o),   32'(m_state));
  endtask

  task automatic expect_disp(input string tag, input int v);
    logic [W-1:0] t;
    t = v[W-1:0];
    cmp(tag, 32'(kb.disp_val), 32'(t));
  endtask

  task automatic apply(input logic kv, input logic isn, input logic iso,
                       input logic ise, input logic [3:0] nv, input logic [1:0] ov);
    @(negedge clk);
    kb.key_valid = kv; kb.is_number = isn; kb.is_op = iso;
    kb.is_eq = ise; kb.num_val = nv; kb.op_val = ov;
    @(posedge clk);
    #1;
    kb.key_valid = 1'b0;
    model_event(kv, isn, iso, ise, nv, ov);
    check_all("step");
  endtask

  task automatic dig(input int d);  apply(1'b1, 1'b1, 1'b0, 1'b0, 4'(d), 2'd0); endtask
  task automatic opk(input int o);  apply(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 2'(o)); endtask
  task automatic eqk();             apply(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 2'd0); endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic       kv, isn, iso, ise;
    logic [3:0] nv;
    logic [1:0] ov;
    int         sel;

    reset_n = 1'b0;
    kb.key_valid = 1'b0; kb.is_number = 1'b0; kb.is_op = 1'b0;
    kb.is_eq = 1'b0; kb.num_val = 4'd0; kb.op_val = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    @(negedge clk);
    reset_n = 1'b1;

    // basic add
    dig(1); dig(2); dig(3);
    expect_disp("add_a", 123);
    opk(1); dig(4); dig(5);
    expect_disp("add_b", 45);
    eqk();
    expect_disp("add_r", 168);
    cmp("add_rv", 32'(kb.res_valid), 32'd1);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
    cmp("add_rv_drop", 32'(kb.res_valid), 32'd0);

    // digit limit and leading zeros
    do_reset();
    dig(1); dig(2); dig(3); dig(4);
    expect_disp("limit", 123);
    do_reset();
    dig(0); dig(0); dig(7);
    expect_disp("lead0", 7);
    dig(8); dig(9); dig(1);
    expect_disp("lead0_cnt", 789);

    // negative result
    do_reset();
    dig(5); opk(2); dig(9); eqk();
    expect_disp("neg", 32'hFFC);

    // chaining then overflow
    do_reset();
    dig(9); dig(9); dig(9); opk(1); dig(9); dig(9); dig(9); opk(1);
    expect_disp("chain", 1998);
    cmp("chain_rv", 32'(kb.res_valid), 32'd1);
    cmp("chain_state", 32'(kb.state_o), 32'(S_OP));
    dig(9); dig(9); dig(9); eqk();
    cmp("ovf_err", 32'(kb.err), 32'd1);
    expect_disp("ovf_disp", 0);
    cmp("ovf_rv", 32'(kb.res_valid), 32'd0);
    dig(3);
    expect_disp("recover", 3);
    cmp("recover_err", 32'(kb.err), 32'd0);

    // ignored and replaced inputs
    do_reset();
    dig(7); opk(1); opk(2); dig(2); eqk();
    expect_disp("replace", 5);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 2'd1);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 2'd3);
    expect_disp("ign_res", 5);
    dig(3); eqk();
    apply(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 2'd0);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 4'd12, 2'd0);
    expect_disp("ign_a", 3);

    // asynchronous reset between edges
    do_reset();
    dig(4); opk(1); dig(3);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async");
    @(negedge clk);
    reset_n = 1'b1;
    dig(2);
    expect_disp("post_rst", 2);

    // randomized key stream
    do_reset();
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 45)      dig($urandom_range(0, 9));
      else if (sel < 65) opk($urandom_range(1, 2));
      else if (sel < 78) eqk();
      else if (sel < 80) do_reset();
      else begin
        kv  = 1'($urandom_range(0, 1));
        isn = 1'($urandom_range(0, 1));
        iso = 1'($urandom_range(0, 1));
        ise = 1'($urandom_range(0, 1));
        nv  = 4'($urandom_range(0, 15));
        ov  = 2'($urandom_range(0, 3));
        apply(kv, isn, iso, ise, nv, ov);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Sequencing controller for the keypad calculator. Consumes the one-cycle key events from the keypad decoder (digit, operator, equals), accumulates two decimal operands, applies add/subtract, and supports operator chaining. Drives a signed binary value and an error flag to the display path. All state is registered; one key event is processed per clock.

## Interface
- `MAX_DIGITS`, default 3: maximum significant decimal digits per typed operand.
- `W`, default 12: width of operand, result and display registers (two's complement).

- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous reset, active low
- `key_valid`  in  1  one-cycle key event strobe (decoder `btn_pressed`)
- `is_number`  in  1  event is a digit
- `is_op`  in  1  event is an operator
- `is_eq`  in  1  event is equals
- `num_val`  in  4  digit 0–9
- `op_val`  in  2  1 = add, 2 = subtract; 0 and 3 are invalid
- `disp_val`  out  W  signed value to display
- `err`  out  1  overflow error latched
- `res_valid`  out  1  one-cycle pulse when a new result is loaded
- `state_o`  out  3  current FSM state, for debug

## Operation
- **Event qualification.** An event exists only when `key_valid`=1. Priority is `is_number` > `is_op` > `is_eq`.
  - `key_valid` with no flag set is ignored.
  - `is_op` with `op_val` equal to 0 or 3 is ignored.
  - `num_val` > 9 is ignored.
- **Registers.** A, B and R are W bits. The latched op is 2 bits. The digit count `cnt` is 0..MAX_DIGITS.
- **Digit accumulate.** X ← X·10 + d, then `cnt`++. The update is applied only when `cnt` < MAX_DIGITS; further digits are ignored.
  - Leading zero: a digit 0 arriving while X = 0 leaves `cnt` unchanged.
- **Arithmetic.** Computed in W+1 bits. A result outside [−2^(W−1), 2^(W−1)−1] is an overflow.
- **States:**
  - `S_A`
    - digit: accumulate into A.
    - op: latch op, clear `cnt`, go to `S_OP`.
    - eq: ignored.
  - `S_OP`
    - digit: B ← d, `cnt` ← (d≠0), go to `S_B`.
    - op: replace the latched op.
    - eq: ignored.
  - `S_B`
    - digit: accumulate into B.
    - eq: R ← A op B, pulse `res_valid`, go to `S_RES`.
    - op: R ← A op B, A ← R, latch the new op, pulse `res_valid`, go to `S_OP`.
    - Overflow on either path: go to `S_ERR` with no `res_valid` pulse.
  - `S_RES`
    - digit: A ← d, `cnt` ← (d≠0), go to `S_A`.
    - op: A ← R, latch op, go to `S_OP`.
    - eq: ignored (no repeat).
  - `S_ERR`
    - digit: clear A, B and R, load A ← d, go to `S_A`.
    - op and eq: ignored.
- **Display source by state.** `S_A` and `S_OP` show A. `S_B` shows B. `S_RES` shows R. `S_ERR` shows 0.
- **`err`.** `err` = 1 exactly while in `S_ERR`.

## Timing
- **Reset.** Asynchronous `reset_n`=0 immediately sets:
  - state = `S_A`
  - A = B = R = 0, op = 0, `cnt` = 0
  - `disp_val` = 0, `err` = 0, `res_valid` = 0
  - Release is synchronous to the next `clk` edge.
  - Reset mid-entry discards all operands.
- **Latency.** An event sampled at clock edge n updates state, registers, `disp_val`, `err` and `res_valid` at edge n, i.e. visible in cycle n+1.
  - `res_valid` is high for exactly one cycle, coincident with the first cycle `disp_val` shows R.
- **Throughput.** Back-to-back events on consecutive cycles are each processed. There is no backpressure and no buffering.

## Structure
- **Package `calc_pkg`:**
  - state encoding: `S_A`, `S_OP`, `S_B`, `S_RES`, `S_ERR`
  - op codes: `OP_ADD` = 2'd1, `OP_SUB` = 2'd2
  - default W and MAX_DIGITS
- **Sub-module `calc_operand_acc`.** Combinational next-value for X·10+d, computed as (X<<3)+(X<<1)+d, plus the next digit count and the limit check. Instantiated once and muxed between A and B.
- **Top `calc_ctrl`.** FSM, A/B/R/op/`cnt` registers, add/sub with overflow detect, display mux.

## Test plan
- **Basic add.** Reset, then 1,2,3,+,4,5,= → `disp_val` reads 123, then 45, then 168; `res_valid` pulses once; `err`=0.
- **Digit limit and leading zeros.** 1,2,3,4 → 123 (the 4 is ignored). Reset, then 0,0,7 → 7 with `cnt`=1.
- **Negative result.** 5,−,9,= → `disp_val` = 12'hFFC (−4).
- **Chaining and overflow.**
  - 9,9,9,+,9,9,9,+ → 1998, `res_valid` pulses, state `S_OP`.
  - Then 9,9,9,= → 2997 overflows → `err`=1, `disp_val`=0, no pulse.
  - Then 3 → `disp_val`=3, `err`=0.
- **Ignored and replaced inputs.**
  - 7,+,− (op replaced by subtract),2,= → 5.
  - `key_valid` with no flag → no change.
  - = in `S_A` → no change.
  - `op_val`=3 → no change.
- **Async reset.** 4,+,3, then drop `reset_n` between clock edges → all outputs 0 before the next edge. After release, 2 → 2.
